// File: rtl/bit_packer.sv
// rtl/bit_packer.sv - variable-bitwidth value packer into fixed-width output words
//
// Packs a length-delimited frame of 1..MAXBITWIDTH-bit values LSB-first,
// back-to-back, into OUTPUT_BITWIDTH-bit words. The final partial word is
// zero-padded, flagged with trm_last and carries its valid-bit count.
//
// Ports:
//   clk                   in   clock, rising edge
//   rstn                  in   synchronous active-low reset
//   bitwidth_d            in   bits per value, latched at frame start
//   num_of_output_values  in   values per frame, latched at frame start
//   rcv_valid/rcv_data    in   input value stream
//   rcv_ready             out  input accepted when rcv_valid && rcv_ready
//   trm_valid             out  output word valid
//   trm_data              out  packed word
//   trm_last              out  last word of frame
//   trm_bits              out  valid bits in trm_data
//   trm_ready             in   downstream accepts word
//   busy                  out  high outside IDLE
//   err_cfg               out  sticky configuration error (cleared by reset only)

module bit_packer #(
   parameter int  MAXBITWIDTH     = 16,
   parameter int  OUTPUT_BITWIDTH = 16,
   parameter int  CNT_WIDTH       = 32,
   localparam int BUFFER_SIZE     = OUTPUT_BITWIDTH + MAXBITWIDTH,
   localparam int BW_W            = $clog2(MAXBITWIDTH) + 1,
   localparam int TB_W            = $clog2(OUTPUT_BITWIDTH) + 1
) (
   input  logic                       clk,
   input  logic                       rstn,
   input  logic [BW_W-1:0]            bitwidth_d,
   input  logic [CNT_WIDTH-1:0]       num_of_output_values,
   input  logic                       rcv_valid,
   input  logic [MAXBITWIDTH-1:0]     rcv_data,
   output logic                       rcv_ready,
   output logic                       trm_valid,
   output logic [OUTPUT_BITWIDTH-1:0] trm_data,
   output logic                       trm_last,
   output logic [TB_W-1:0]            trm_bits,
   input  logic                       trm_ready,
   output logic                       busy,
   output logic                       err_cfg
);

   localparam int FILL_W = $clog2(BUFFER_SIZE + 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2,
      S_ERR   = 2'd3
   } state_t;

   state_t                 r_state;
   state_t                 w_next;

   logic [BUFFER_SIZE-1:0] r_buf;
   logic [FILL_W-1:0]      r_fill;
   logic [CNT_WIDTH-1:0]   r_count;
   logic [CNT_WIDTH-1:0]   r_n;
   logic [BW_W-1:0]        r_bw;

   logic                   w_rcv_ready;
   logic                   w_trm_valid;
   logic                   w_trm_last;
   logic [TB_W-1:0]        w_trm_bits;
   logic                   w_accept;
   logic                   w_emit;
   logic                   w_cfg_bad;
   logic [MAXBITWIDTH-1:0] w_mask;
   logic [BUFFER_SIZE-1:0] w_ins;
   logic [FILL_W-1:0]      w_word_fill;

   assign w_word_fill = FILL_W'(OUTPUT_BITWIDTH);

   assign w_cfg_bad = (bitwidth_d == '0) ||
                      (bitwidth_d > BW_W'(MAXBITWIDTH)) ||
                      (num_of_output_values == '0);

   // Mask of the low r_bw bits; r_bw==0 only occurs outside RUN where it is unused.
   assign w_mask = {MAXBITWIDTH{1'b1}} >> (BW_W'(MAXBITWIDTH) - r_bw);
   assign w_ins  = {{OUTPUT_BITWIDTH{1'b0}}, rcv_data & w_mask} << r_fill;

   assign w_accept = rcv_valid && w_rcv_ready;
   assign w_emit   = w_trm_valid && trm_ready;

   // State register
   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state logic
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (rcv_valid) begin
               w_next = w_cfg_bad ? S_ERR : S_RUN;
            end
         end
         S_RUN: begin
            if (w_accept && ((r_count + CNT_WIDTH'(1)) == r_n)) begin
               w_next = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (w_emit && w_trm_last) begin
               w_next = S_IDLE;
            end
         end
         default: w_next = S_ERR;
      endcase
   end

   // Output logic, driven from registers only so ready never depends on valid
   always_comb begin
      w_rcv_ready = 1'b0;
      w_trm_valid = 1'b0;
      w_trm_last  = 1'b0;
      w_trm_bits  = '0;
      case (r_state)
         S_RUN: begin
            w_rcv_ready = (r_fill < w_word_fill);
            w_trm_valid = (r_fill >= w_word_fill);
            w_trm_bits  = TB_W'(OUTPUT_BITWIDTH);
         end
         S_DRAIN: begin
            w_trm_valid = (r_fill != '0);
            w_trm_last  = (r_fill <= w_word_fill);
            w_trm_bits  = w_trm_last ? TB_W'(r_fill) : TB_W'(OUTPUT_BITWIDTH);
         end
         default: begin
            w_rcv_ready = 1'b0;
         end
      endcase
   end

   // Datapath: buffer, fill level, value counter and latched configuration.
   // Bits above r_fill are always zero, so the drain word is implicitly padded.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_buf   <= '0;
         r_fill  <= '0;
         r_count <= '0;
         r_n     <= '0;
         r_bw    <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (rcv_valid) begin
                  r_bw    <= bitwidth_d;
                  r_n     <= num_of_output_values;
                  r_buf   <= '0;
                  r_fill  <= '0;
                  r_count <= '0;
               end
            end
            S_RUN: begin
               if (w_accept) begin
                  r_buf   <= r_buf | w_ins;
                  r_fill  <= r_fill + FILL_W'(r_bw);
                  r_count <= r_count + CNT_WIDTH'(1);
               end else if (w_emit) begin
                  r_buf  <= r_buf >> OUTPUT_BITWIDTH;
                  r_fill <= r_fill - w_word_fill;
               end
            end
            S_DRAIN: begin
               if (w_emit) begin
                  if (w_trm_last) begin
                     r_buf   <= '0;
                     r_fill  <= '0;
                     r_count <= '0;
                  end else begin
                     r_buf  <= r_buf >> OUTPUT_BITWIDTH;
                     r_fill <= r_fill - w_word_fill;
                  end
               end
            end
            default: begin
               r_buf <= r_buf;
            end
         endcase
      end
   end

   assign rcv_ready = w_rcv_ready;
   assign trm_valid = w_trm_valid;
   assign trm_last  = w_trm_last;
   assign trm_bits  = w_trm_bits;
   assign trm_data  = r_buf[OUTPUT_BITWIDTH-1:0];
   assign busy      = (r_state != S_IDLE);
   assign err_cfg   = (r_state == S_ERR);

endmodule

// File: tb/tb_bit_packer.sv
// tb/tb_bit_packer.sv - self-checking bench for bit_packer

module tb_bit_packer;

   logic        clk = 1'b0;
   logic        rstn;
   logic [4:0]  bitwidth_d;
   logic [31:0] num_of_output_values;
   logic        rcv_valid;
   logic [15:0] rcv_data;
   logic        rcv_ready;
   logic        trm_valid;
   logic [15:0] trm_data;
   logic        trm_last;
   logic [4:0]  trm_bits;
   logic        trm_ready = 1'b1;
   logic        busy;
   logic        err_cfg;

   always #5 clk = ~clk;

   bit_packer dut (
      .clk                  (clk),
      .rstn                 (rstn),
      .bitwidth_d           (bitwidth_d),
      .num_of_output_values (num_of_output_values),
      .rcv_valid            (rcv_valid),
      .rcv_data             (rcv_data),
      .rcv_ready            (rcv_ready),
      .trm_valid            (trm_valid),
      .trm_data             (trm_data),
      .trm_last             (trm_last),
      .trm_bits             (trm_bits),
      .trm_ready            (trm_ready),
      .busy                 (busy),
      .err_cfg              (err_cfg)
   );

   typedef struct {
      logic [15:0] data;
      logic        last;
      logic [4:0]  bits;
   } word_t;

   word_t exp_q[$];
   word_t got_q[$];
   int    checks   = 0;
   int    failures = 0;
   int    ready_mode = 0;   // 0: always ready, 1: random, 2: held low

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
      end
   endtask

   // Reference model: serialise every value into a bit queue, then cut words.
   task automatic model_frame(input int bw, input int n, input logic [15:0] vals[$]);
      bit    bq[$];
      word_t w;
      for (int i = 0; i < n; i++)
         for (int b = 0; b < bw; b++)
            bq.push_back(vals[i][b]);
      while (bq.size() > 0) begin
         w.data = '0;
         w.bits = '0;
         for (int b = 0; b < 16 && bq.size() > 0; b++) begin
            w.data[b] = bq.pop_front();
            w.bits    = w.bits + 5'd1;
         end
         w.last = (bq.size() == 0);
         exp_q.push_back(w);
      end
   endtask

   always @(posedge clk) begin
      #1;
      case (ready_mode)
         0:       trm_ready = 1'b1;
         1:       trm_ready = ($urandom_range(0, 3) != 0);
         default: trm_ready = 1'b0;
      endcase
   end

   // Compare process
   logic  prev_stall = 1'b0;
   word_t prev_w;
   word_t cmp_e;
   always @(negedge clk) begin
      if (!rstn) begin
         prev_stall = 1'b0;
      end else begin
         check("ready_valid_exclusive", rcv_ready & trm_valid, 1'b0);
         if (prev_stall) begin
            check("hold_valid", trm_valid, 1'b1);
            check("hold_data",  trm_data,  prev_w.data);
            check("hold_last",  trm_last,  prev_w.last);
            check("hold_bits",  trm_bits,  prev_w.bits);
         end
         if (trm_valid && trm_ready) begin
            cmp_e.data = trm_data;
            cmp_e.last = trm_last;
            cmp_e.bits = trm_bits;
            got_q.push_back(cmp_e);
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_word: actual=0x%0h required=none", trm_data);
            end else begin
               cmp_e = exp_q.pop_front();
               check("word_data", trm_data, cmp_e.data);
               check("word_last", trm_last, cmp_e.last);
               check("word_bits", trm_bits, cmp_e.bits);
            end
         end
         prev_stall  = trm_valid && !trm_ready;
         prev_w.data = trm_data;
         prev_w.last = trm_last;
         prev_w.bits = trm_bits;
      end
   end

   task automatic send_frame(input int bw, input int n, input logic [15:0] vals[$],
                             input int abort_after, input bit gaps);
      int idx   = 0;
      int guard = 0;
      bit acc;
      bitwidth_d           = 5'(bw);
      num_of_output_values = 32'(n);
      rcv_data             = vals[0];
      rcv_valid            = 1'b1;
      while (idx < n && idx != abort_after) begin
         @(negedge clk);
         acc = rcv_valid && rcv_ready;
         @(posedge clk);
         #1;
         guard++;
         if (guard > 2000) begin
            checks++;
            failures++;
            $display("FAIL send_timeout: actual=%0d required=%0d", idx, n);
            break;
         end
         if (acc) begin
            idx++;
            bitwidth_d           = 5'($urandom);
            num_of_output_values = $urandom;
            if (idx < n) rcv_data = vals[idx];
         end
         if (gaps) rcv_valid = ($urandom_range(0, 3) != 0);
      end
      rcv_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int k;
      for (k = 0; k < 1000; k++) begin
         @(negedge clk);
         if (!busy && exp_q.size() == 0) break;
      end
      if (k == 1000) begin
         checks++;
         failures++;
         $display("FAIL idle_timeout: actual=%0d required=0 pending words", exp_q.size());
      end
   endtask

   task automatic pulse_reset();
      rstn = 1'b0;
      @(posedge clk);
      #1;
      rstn = 1'b1;
   endtask

   logic [15:0] vals[$];
   int          bw_cfg[3] = '{0, 17, 4};
   int          n_cfg[3]  = '{4, 4, 0};

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: actual=timeout required=finish");
      $fatal(1);
   end

   initial begin
      rstn = 1'b0;
      rcv_valid = 1'b0;
      rcv_data = '0;
      bitwidth_d = '0;
      num_of_output_values = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_rcv_ready", rcv_ready, 1'b0);
      check("rst_trm_valid", trm_valid, 1'b0);
      check("rst_trm_last",  trm_last,  1'b0);
      check("rst_trm_bits",  trm_bits,  5'd0);
      check("rst_busy",      busy,      1'b0);
      check("rst_err_cfg",   err_cfg,   1'b0);
      @(posedge clk);
      #1;
      rstn = 1'b1;

      // bw=4, n=8, 1..8: exact fit, two words
      vals = '{16'h1, 16'h2, 16'h3, 16'h4, 16'h5, 16'h6, 16'h7, 16'h8};
      got_q.delete();
      model_frame(4, 8, vals);
      check("model_s1_w0", exp_q[0].data, 16'h4321);
      check("model_s1_w1", exp_q[1].data, 16'h8765);
      send_frame(4, 8, vals, -1, 1'b0);
      wait_idle();
      check("s1_count", got_q.size(), 2);
      if (got_q.size() == 2) begin
         check("s1_w0_data", got_q[0].data, 16'h4321);
         check("s1_w0_last", got_q[0].last, 1'b0);
         check("s1_w1_data", got_q[1].data, 16'h8765);
         check("s1_w1_last", got_q[1].last, 1'b1);
         check("s1_w1_bits", got_q[1].bits, 5'd16);
      end

      // bw=5, n=4: partial trailer of 4 bits
      vals = '{16'h1F, 16'h00, 16'h15, 16'h0A};
      got_q.delete();
      model_frame(5, 4, vals);
      send_frame(5, 4, vals, -1, 1'b0);
      wait_idle();
      check("s2_count", got_q.size(), 2);
      if (got_q.size() == 2) begin
         check("s2_w0_data", got_q[0].data, 16'h541F);
         check("s2_w0_bits", got_q[0].bits, 5'd16);
         check("s2_w1_data", got_q[1].data, 16'h0005);
         check("s2_w1_last", got_q[1].last, 1'b1);
         check("s2_w1_bits", got_q[1].bits, 5'd4);
      end

      // bw=3, n=1 with garbage upper bits
      vals = '{16'hFFFF};
      got_q.delete();
      model_frame(3, 1, vals);
      send_frame(3, 1, vals, -1, 1'b0);
      wait_idle();
      check("s3_count", got_q.size(), 1);
      if (got_q.size() == 1) begin
         check("s3_data", got_q[0].data, 16'h0007);
         check("s3_last", got_q[0].last, 1'b1);
         check("s3_bits", got_q[0].bits, 5'd3);
      end

      // Scenario 1 with downstream stalled for 5 cycles
      vals = '{16'h1, 16'h2, 16'h3, 16'h4, 16'h5, 16'h6, 16'h7, 16'h8};
      got_q.delete();
      model_frame(4, 8, vals);
      ready_mode = 2;
      @(posedge clk);
      #1;
      fork
         send_frame(4, 8, vals, -1, 1'b0);
         begin
            int k;
            for (k = 0; k < 200; k++) begin
               @(negedge clk);
               if (trm_valid) break;
            end
            check("stall_valid_seen", trm_valid, 1'b1);
            for (int c = 0; c < 5; c++) begin
               check("stall_data",      trm_data,  16'h4321);
               check("stall_rcv_ready", rcv_ready, 1'b0);
               @(negedge clk);
            end
            ready_mode = 0;
         end
      join
      wait_idle();
      check("s4_count", got_q.size(), 2);
      if (got_q.size() == 2) begin
         check("s4_w0_data", got_q[0].data, 16'h4321);
         check("s4_w1_data", got_q[1].data, 16'h8765);
      end

      // Configuration errors
      for (int e = 0; e < 3; e++) begin
         pulse_reset();
         bitwidth_d           = 5'(bw_cfg[e]);
         num_of_output_values = 32'(n_cfg[e]);
         rcv_valid            = 1'b1;
         rcv_data             = 16'h1234;
         for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (c > 0) begin
               check("err_cfg_set",   err_cfg,   1'b1);
               check("err_busy",      busy,      1'b1);
               check("err_rcv_ready", rcv_ready, 1'b0);
               check("err_trm_valid", trm_valid, 1'b0);
            end
         end
         rcv_valid = 1'b0;
         rstn = 1'b0;
         @(posedge clk);
         @(negedge clk);
         check("err_cleared", err_cfg, 1'b0);
         check("err_idle",    busy,    1'b0);
         #4;
         rstn = 1'b1;
      end

      // Reset mid-frame, then a clean follow-on frame
      @(posedge clk);
      #1;
      vals = '{16'h1, 16'h2, 16'h3, 16'h4, 16'h5, 16'h6, 16'h7, 16'h8};
      send_frame(4, 8, vals, 3, 1'b0);
      rstn = 1'b0;
      exp_q.delete();
      @(posedge clk);
      @(negedge clk);
      check("mid_rcv_ready", rcv_ready, 1'b0);
      check("mid_trm_valid", trm_valid, 1'b0);
      check("mid_trm_last",  trm_last,  1'b0);
      check("mid_trm_bits",  trm_bits,  5'd0);
      check("mid_trm_data",  trm_data,  16'h0);
      check("mid_busy",      busy,      1'b0);
      check("mid_err_cfg",   err_cfg,   1'b0);
      @(posedge clk);
      #1;
      rstn = 1'b1;
      vals = '{16'hAB, 16'hCD};
      got_q.delete();
      model_frame(8, 2, vals);
      send_frame(8, 2, vals, -1, 1'b0);
      wait_idle();
      check("s6_count", got_q.size(), 1);
      if (got_q.size() == 1) begin
         check("s6_data", got_q[0].data, 16'hCDAB);
         check("s6_last", got_q[0].last, 1'b1);
         check("s6_bits", got_q[0].bits, 5'd16);
      end

      // Randomised back-to-back frames with input gaps and downstream stalls
      ready_mode = 1;
      for (int f = 0; f < 40; f++) begin
         int bw;
         int n;
         bw = $urandom_range(1, 16);
         n  = $urandom_range(1, 12);
         vals.delete();
         for (int i = 0; i < n; i++) vals.push_back(16'($urandom));
         model_frame(bw, n, vals);
         send_frame(bw, n, vals, -1, 1'b1);
      end
      wait_idle();
      ready_mode = 0;
      check("rand_drained", exp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
